// File: rtl/switch_input_port.sv
// -----------------------------------------------------------------------------
// switch_input_port
//
// Memory-mapped read-side peripheral. The CPU polls the 16 board switches and
// a confirmation button through the IO read bus. The button is synchronised
// and debounced. Every accepted press (rising edge of the debounced level)
// captures a switch snapshot into a holding register, raises a valid flag,
// bumps a wrapping press counter and, if the previous snapshot was never
// collected, raises an overrun flag.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   switchCtrl    IO read strobe, one cycle per CPU load (qualifies side effects)
//   address       CPU load address
//   switchInput   raw board switches, asynchronous to clk
//   confirmation  raw confirm button, active-high, bouncing
//   dataIOInput   read data, zero-extended, combinational from register state
//   pressPulse    one-cycle pulse per accepted press (registered)
//
// Address map (anything else reads 0):
//   0xFFFF_FFC0  live synchronised switches
//   0xFFFF_FFC8  snapshot register          (read clears validFlag)
//   0xFFFF_FFCC  {29'b0, btnStable, overrunFlag, validFlag} (read clears overrun)
//   0xFFFF_FFCE  press counter
// -----------------------------------------------------------------------------
module switch_input_port #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        switchCtrl,
  input  logic [31:0] address,
  input  logic [15:0] switchInput,
  input  logic        confirmation,
  output logic [31:0] dataIOInput,
  output logic        pressPulse
);

  localparam logic [31:0] ADDR_LIVE   = 32'hFFFF_FFC0;
  localparam logic [31:0] ADDR_SNAP   = 32'hFFFF_FFC8;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFCC;
  localparam logic [31:0] ADDR_COUNT  = 32'hFFFF_FFCE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages
  logic        r_btn_meta;
  logic        r_btn_sync;
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;

  // Debounce state
  logic             r_btn_stable;
  logic [CNT_W-1:0] r_dbc_cnt;

  // Press detection and capture state
  logic        r_stable_d;
  logic        r_press_pulse;
  logic [15:0] r_snap;
  logic        r_valid;
  logic        r_overrun;
  logic [15:0] r_press_cnt;

  // Combinational helpers
  logic        w_differ;
  logic        w_cnt_done;
  logic        w_rd_snap;
  logic        w_rd_status;
  logic        w_overrun_set;
  logic [31:0] w_read_data;

  assign w_differ    = (r_btn_sync != r_btn_stable);
  assign w_cnt_done  = (r_dbc_cnt == CNT_LAST);
  assign w_rd_snap   = switchCtrl & (address == ADDR_SNAP);
  assign w_rd_status = switchCtrl & (address == ADDR_STATUS);
  // A second capture before the snapshot was collected is an overrun, unless
  // the CPU is collecting it on this very edge.
  assign w_overrun_set = r_press_pulse & r_valid & ~w_rd_snap;

  // Two-flop synchronisers for the button and every switch bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_sw_meta  <= 16'h0000;
      r_sw_sync  <= 16'h0000;
    end else begin
      r_btn_meta <= confirmation;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= switchInput;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted level; any return to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_stable <= 1'b0;
      r_dbc_cnt    <= '0;
    end else if (!w_differ) begin
      r_btn_stable <= r_btn_stable;
      r_dbc_cnt    <= '0;
    end else if (w_cnt_done) begin
      r_btn_stable <= ~r_btn_stable;
      r_dbc_cnt    <= '0;
    end else begin
      r_btn_stable <= r_btn_stable;
      r_dbc_cnt    <= r_dbc_cnt + CNT_ONE;
    end
  end

  // Rising-edge detect on the debounced level; pulse lands one cycle after
  // the debounced level goes high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable_d    <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_stable_d    <= r_btn_stable;
      r_press_pulse <= r_btn_stable & ~r_stable_d;
    end
  end

  // Snapshot register and press counter, loaded on each accepted press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap      <= 16'h0000;
      r_press_cnt <= 16'h0000;
    end else if (r_press_pulse) begin
      r_snap      <= r_sw_sync;
      r_press_cnt <= r_press_cnt + 16'h0001;
    end else begin
      r_snap      <= r_snap;
      r_press_cnt <= r_press_cnt;
    end
  end

  // Valid flag: a capture sets it and beats a simultaneous snapshot read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (r_press_pulse) begin
      r_valid <= 1'b1;
    end else if (w_rd_snap) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Overrun flag: set wins over a simultaneous status read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (w_rd_status) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  // Zero-latency read mux; returns pre-clear values since flags update at the edge
  always_comb begin
    w_read_data = 32'h0000_0000;
    case (address)
      ADDR_LIVE:   w_read_data = {16'h0000, r_sw_sync};
      ADDR_SNAP:   w_read_data = {16'h0000, r_snap};
      ADDR_STATUS: w_read_data = {29'h0000_0000, r_btn_stable, r_overrun, r_valid};
      ADDR_COUNT:  w_read_data = {16'h0000, r_press_cnt};
      default:     w_read_data = 32'h0000_0000;
    endcase
  end

  assign dataIOInput = w_read_data;
  assign pressPulse  = r_press_pulse;

endmodule

// File: tb/tb_switch_input_port.sv
// -----------------------------------------------------------------------------
// tb_switch_input_port
//
// Directed bench for switch_input_port with DEBOUNCE_CYCLES=8. Inputs are
// driven on the falling clock edge; outputs are sampled there too. Each read
// pushes its expected value into a queue, which is popped and compared once
// the combinational read data has settled.
// -----------------------------------------------------------------------------
module tb_switch_input_port;

  localparam logic [31:0] A_LIVE   = 32'hFFFF_FFC0;
  localparam logic [31:0] A_SNAP   = 32'hFFFF_FFC8;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FFCC;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_FFCE;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_FFD0;

  logic        clk;
  logic        rst;
  logic        switchCtrl;
  logic [31:0] address;
  logic [15:0] switchInput;
  logic        confirmation;
  logic [31:0] dataIOInput;
  logic        pressPulse;

  int          n_checks;
  int          n_fail;
  int          n_pulses;
  logic [31:0] exp_q[$];

  switch_input_port #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switchCtrl(switchCtrl),
    .address(address),
    .switchInput(switchInput),
    .confirmation(confirmation),
    .dataIOInput(dataIOInput),
    .pressPulse(pressPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulse cycles, sampled away from the active edge
  always @(negedge clk) begin
    if (pressPulse === 1'b1) n_pulses = n_pulses + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU load: strobe for a single cycle starting at the current falling edge
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    switchCtrl = 1'b1;
    address    = addr;
    #1;
    e = exp_q.pop_front();
    check(tag, dataIOInput, e);
    @(negedge clk);
    switchCtrl = 1'b0;
    address    = 32'h0000_0000;
  endtask

  // Clean press and release, long enough to qualify both edges
  task automatic press();
    confirmation = 1'b1;
    tick(14);
    confirmation = 1'b0;
    tick(14);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    n_pulses     = 0;
    rst          = 1'b0;
    switchCtrl   = 1'b0;
    address      = 32'h0000_0000;
    switchInput  = 16'hFFFF;
    confirmation = 1'b1;
    tick(3);

    // Reset held with button down and all switches on
    rd("rst_live",   A_LIVE,   32'h0000_0000);
    rd("rst_snap",   A_SNAP,   32'h0000_0000);
    rd("rst_status", A_STATUS, 32'h0000_0000);
    rd("rst_count",  A_COUNT,  32'h0000_0000);
    check("rst_pulse", {31'h0, pressPulse}, 32'h0);

    // Release reset with button still held: must re-qualify, then one press
    rst = 1'b1;
    tick(10);
    check("lat_before", {31'h0, pressPulse}, 32'h0);
    tick(1);
    check("lat_pulse", {31'h0, pressPulse}, 32'h1);
    tick(1);
    check("lat_after", {31'h0, pressPulse}, 32'h0);
    tick(7);
    check("rst_one_pulse", 32'(n_pulses), 32'd1);
    rd("rst_count1", A_COUNT, 32'h0000_0001);
    rd("live_ffff",  A_LIVE,  32'h0000_FFFF);
    confirmation = 1'b0;
    tick(14);
    rd("rel_status", A_STATUS, 32'h0000_0001);
    rd("rel_snap",   A_SNAP,   32'h0000_FFFF);
    rd("clr_status", A_STATUS, 32'h0000_0000);

    // Bounce: toggle every 3 cycles, ending low, then hold high
    for (int i = 0; i < 10; i++) begin
      confirmation = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(3);
    end
    check("bounce_nopulse", 32'(n_pulses), 32'd1);
    confirmation = 1'b1;
    tick(10);
    check("bounce_before", {31'h0, pressPulse}, 32'h0);
    tick(1);
    check("bounce_pulse", {31'h0, pressPulse}, 32'h1);
    tick(1);
    check("bounce_after", {31'h0, pressPulse}, 32'h0);
    check("bounce_count", 32'(n_pulses), 32'd2);
    confirmation = 1'b0;
    tick(14);

    // Seven stable cycles is one short of qualifying
    confirmation = 1'b1;
    tick(7);
    confirmation = 1'b0;
    tick(20);
    check("hold7_nopulse", 32'(n_pulses), 32'd2);
    rd("bounce_snap", A_SNAP, 32'h0000_FFFF);

    // Capture and clear
    switchInput = 16'hA5C3;
    tick(3);
    confirmation = 1'b1;
    tick(14);
    rd("cap_status",  A_STATUS, 32'h0000_0005);
    rd("cap_snap",    A_SNAP,   32'h0000_A5C3);
    rd("cap_status2", A_STATUS, 32'h0000_0004);
    confirmation = 1'b0;
    tick(14);

    // Overrun: two presses with no snapshot read
    switchInput = 16'h1111;
    tick(3);
    press();
    switchInput = 16'h2222;
    tick(3);
    press();
    rd("ovr_status",  A_STATUS, 32'h0000_0003);
    rd("ovr_status2", A_STATUS, 32'h0000_0001);
    rd("ovr_snap",    A_SNAP,   32'h0000_2222);
    rd("ovr_status3", A_STATUS, 32'h0000_0000);

    // Collision: snapshot read on the pulse cycle while valid is already set
    switchInput = 16'h3333;
    tick(3);
    press();
    switchInput = 16'h4444;
    tick(3);
    confirmation = 1'b1;
    tick(11);
    check("col_pulse", {31'h0, pressPulse}, 32'h1);
    rd("col_snap_old", A_SNAP,   32'h0000_3333);
    rd("col_status",   A_STATUS, 32'h0000_0005);
    confirmation = 1'b0;
    tick(14);
    rd("col_snap_new", A_SNAP,  32'h0000_4444);
    rd("count7",       A_COUNT, 32'h0000_0007);

    // Counter wrap
    force dut.r_press_cnt = 16'hFFFF;
    tick(1);
    release dut.r_press_cnt;
    rd("wrap_pre", A_COUNT, 32'h0000_FFFF);
    press();
    rd("wrap_post", A_COUNT, 32'h0000_0000);
    rd("unmapped",  A_UNMAP, 32'h0000_0000);
    rd("live_4444", A_LIVE,  32'h0000_4444);

    // Reset mid-debounce clears everything; held button re-qualifies afterwards
    confirmation = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    rd("mid_status", A_STATUS, 32'h0000_0000);
    rd("mid_snap",   A_SNAP,   32'h0000_0000);
    rd("mid_count",  A_COUNT,  32'h0000_0000);
    rst = 1'b1;
    tick(10);
    check("mid_before", {31'h0, pressPulse}, 32'h0);
    tick(1);
    check("mid_pulse", {31'h0, pressPulse}, 32'h1);
    tick(2);
    rd("mid_count1", A_COUNT, 32'h0000_0001);
    rd("mid_snap1",  A_SNAP,  32'h0000_4444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
